// File: rtl/if_stage.sv
// ----------------------------------------------------------------------------
// if_stage : instruction-fetch stage.
// Owns the PC, addresses a combinational instruction memory and captures the
// returned word together with its PC (and PC+4) into the IF/ID register.
// Handles hazard stalls, EX-stage redirects and a BOOT/RUN/HALT state machine.
//
// Optional feature macro: IF_MISALIGN_TRAP_EN
//   defined   : a redirect with target[1:0] != 0 loads the aligned PC, raises
//               the sticky o_misalign flag and parks the stage in HALT.
//   undefined : target[1:0] is silently cleared and o_misalign stays 0.
// ----------------------------------------------------------------------------
module if_stage #(
    parameter logic [31:0] P_RESET_PC  = 32'h0000_0000,
    parameter int          P_ADDR_BITS = 20,
    parameter logic [31:0] P_NOP       = 32'h0000_0013
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic [31:0] o_imem_adr,
    input  logic [31:0] i_imem_instr,
    input  logic        i_stall,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    input  logic        i_halt,
    output logic [31:0] o_if_id_instr,
    output logic [31:0] o_if_id_pc,
    output logic [31:0] o_if_id_pc4,
    output logic        o_if_id_valid,
    output logic [1:0]  o_state,
    output logic        o_misalign
);

    // Implemented address bits; everything above is forced to zero.
    localparam logic [31:0] ADDR_MASK  = (P_ADDR_BITS >= 32) ? 32'hFFFF_FFFF
                                       : ((32'h1 << P_ADDR_BITS) - 32'h1);
    // Word-aligned view of the address space: PC[1:0] is never set.
    localparam logic [31:0] ALIGN_MASK = ADDR_MASK & 32'hFFFF_FFFC;
    localparam logic [31:0] RESET_PC   = P_RESET_PC & ALIGN_MASK;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t      state_r;
    logic [31:0] pc_r;
    logic [31:0] if_id_instr_r;
    logic [31:0] if_id_pc_r;
    logic [31:0] if_id_pc4_r;
    logic        if_id_valid_r;
    logic        misalign_r;

    logic [31:0] pc4_s;
    logic [31:0] redir_pc_s;
    logic        redir_misalign_s;
    state_t      redir_state_s;

    // Sequential PC successor, wrapping inside the implemented address space.
    function automatic logic [31:0] f_next_pc(input logic [31:0] pc);
        f_next_pc = (pc + 32'd4) & ALIGN_MASK;
    endfunction

    // Redirect target clipped to the implemented, word-aligned address space.
    function automatic logic [31:0] f_align_target(input logic [31:0] tgt);
        f_align_target = tgt & ALIGN_MASK;
    endfunction

    // Derive the sequential PC and everything a redirect would load this cycle.
    always_comb begin
        pc4_s      = f_next_pc(pc_r);
        redir_pc_s = f_align_target(i_redirect_pc);
`ifdef IF_MISALIGN_TRAP_EN
        redir_misalign_s = (i_redirect_pc[1:0] != 2'b00);
`else
        redir_misalign_s = 1'b0;
`endif
        if (redir_misalign_s) begin
            redir_state_s = ST_HALT;
        end else begin
            redir_state_s = ST_RUN;
        end
    end

    // Fetch FSM: owns PC, IF/ID register, state and the sticky misalign flag.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r       <= ST_BOOT;
            pc_r          <= RESET_PC;
            if_id_instr_r <= P_NOP;
            if_id_pc_r    <= 32'h0000_0000;
            if_id_pc4_r   <= 32'h0000_0000;
            if_id_valid_r <= 1'b0;
            misalign_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_BOOT: begin
                    // One settling cycle with a bubble; a redirect may still retarget the PC.
                    if_id_instr_r <= P_NOP;
                    if_id_pc_r    <= 32'h0000_0000;
                    if_id_pc4_r   <= 32'h0000_0000;
                    if_id_valid_r <= 1'b0;
                    if (i_redirect) begin
                        pc_r       <= redir_pc_s;
                        state_r    <= redir_state_s;
                        misalign_r <= misalign_r | redir_misalign_s;
                    end else begin
                        state_r    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (i_redirect) begin
                        // Redirect beats halt and stall: squash the fetched word.
                        pc_r          <= redir_pc_s;
                        state_r       <= redir_state_s;
                        misalign_r    <= misalign_r | redir_misalign_s;
                        if_id_instr_r <= P_NOP;
                        if_id_pc_r    <= 32'h0000_0000;
                        if_id_pc4_r   <= 32'h0000_0000;
                        if_id_valid_r <= 1'b0;
                    end else if (i_halt) begin
                        state_r       <= ST_HALT;
                        if_id_instr_r <= P_NOP;
                        if_id_pc_r    <= 32'h0000_0000;
                        if_id_pc4_r   <= 32'h0000_0000;
                        if_id_valid_r <= 1'b0;
                    end else if (i_stall) begin
                        // Hold PC and IF/ID exactly as they are.
                        state_r       <= ST_RUN;
                    end else begin
                        pc_r          <= pc4_s;
                        state_r       <= ST_RUN;
                        if_id_instr_r <= i_imem_instr;
                        if_id_pc_r    <= pc_r;
                        if_id_pc4_r   <= pc4_s;
                        if_id_valid_r <= 1'b1;
                    end
                end
                ST_HALT: begin
                    // Parked: keep issuing bubbles until a redirect restarts fetch.
                    if_id_instr_r <= P_NOP;
                    if_id_pc_r    <= 32'h0000_0000;
                    if_id_pc4_r   <= 32'h0000_0000;
                    if_id_valid_r <= 1'b0;
                    if (i_redirect) begin
                        pc_r       <= redir_pc_s;
                        state_r    <= redir_state_s;
                        misalign_r <= misalign_r | redir_misalign_s;
                    end else begin
                        state_r    <= ST_HALT;
                    end
                end
                default: begin
                    // Unreachable encoding: recover through BOOT with a bubble.
                    state_r       <= ST_BOOT;
                    if_id_instr_r <= P_NOP;
                    if_id_pc_r    <= 32'h0000_0000;
                    if_id_pc4_r   <= 32'h0000_0000;
                    if_id_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign o_imem_adr    = pc_r;
    assign o_if_id_instr = if_id_instr_r;
    assign o_if_id_pc    = if_id_pc_r;
    assign o_if_id_pc4   = if_id_pc4_r;
    assign o_if_id_valid = if_id_valid_r;
    assign o_state       = state_r;
    assign o_misalign    = misalign_r;

endmodule

// File: tb/tb_if_stage.sv
// ----------------------------------------------------------------------------
// tb_if_stage : directed self-checking bench for if_stage (default parameters).
// A small combinational memory model returns fixed words at 0/4 and an
// address-tagged pattern elsewhere.
// ----------------------------------------------------------------------------
module tb_if_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic [31:0] imem_adr;
    logic [31:0] imem_instr;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        halt;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic [1:0]  state;
    logic        misalign;

    int n_checks = 0;
    int n_fail   = 0;

    if_stage dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .o_imem_adr    (imem_adr),
        .i_imem_instr  (imem_instr),
        .i_stall       (stall),
        .i_redirect    (redirect),
        .i_redirect_pc (redirect_pc),
        .i_halt        (halt),
        .o_if_id_instr (if_id_instr),
        .o_if_id_pc    (if_id_pc),
        .o_if_id_pc4   (if_id_pc4),
        .o_if_id_valid (if_id_valid),
        .o_state       (state),
        .o_misalign    (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0)      mem_word = 32'h0050_0093;
        else if (a == 32'h4) mem_word = 32'h0010_0113;
        else                 mem_word = 32'hA000_0000 | a;
    endfunction

    assign imem_instr = mem_word(imem_adr);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; halt = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (imem_adr !== 32'h0) begin n_fail++; $display("FAIL rst_adr got %h exp %h", imem_adr, 32'h0); end
        n_checks++; if (state !== 2'd0) begin n_fail++; $display("FAIL rst_state got %0d exp 0", state); end
        n_checks++; if (if_id_instr !== NOP) begin n_fail++; $display("FAIL rst_instr got %h exp %h", if_id_instr, NOP); end
        n_checks++; if (if_id_pc !== 32'h0 || if_id_pc4 !== 32'h0) begin n_fail++; $display("FAIL rst_pcs got %h/%h exp 0/0", if_id_pc, if_id_pc4); end
        n_checks++; if (if_id_valid !== 1'b0 || misalign !== 1'b0) begin n_fail++; $display("FAIL rst_flags got %b%b exp 00", if_id_valid, misalign); end
        rst_n = 1'b1;
        n_checks++; if (state !== 2'd0 || if_id_valid !== 1'b0) begin n_fail++; $display("FAIL boot_hold got st=%0d v=%b exp st=0 v=0", state, if_id_valid); end
        step();
        n_checks++; if (state !== 2'd1 || if_id_valid !== 1'b0 || imem_adr !== 32'h0) begin n_fail++; $display("FAIL boot_exit got st=%0d v=%b adr=%h exp 1/0/0", state, if_id_valid, imem_adr); end
        step();
        n_checks++; if (if_id_instr !== 32'h0050_0093 || if_id_pc !== 32'h0 || if_id_pc4 !== 32'h4 || if_id_valid !== 1'b1) begin
            n_fail++; $display("FAIL first_fetch got %h pc=%h pc4=%h v=%b exp 00500093/0/4/1", if_id_instr, if_id_pc, if_id_pc4, if_id_valid); end
        n_checks++; if (imem_adr !== 32'h4) begin n_fail++; $display("FAIL first_adr got %h exp 4", imem_adr); end
        step();
        n_checks++; if (if_id_instr !== 32'h0010_0113 || if_id_pc !== 32'h4 || imem_adr !== 32'h8) begin
            n_fail++; $display("FAIL second_fetch got %h pc=%h adr=%h exp 00100113/4/8", if_id_instr, if_id_pc, imem_adr); end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++; if (imem_adr !== 32'h8 || if_id_pc !== 32'h4 || if_id_instr !== 32'h0010_0113 || if_id_valid !== 1'b1) begin
                n_fail++; $display("FAIL stall_hold[%0d] got adr=%h pc=%h ins=%h v=%b exp 8/4/00100113/1", i, imem_adr, if_id_pc, if_id_instr, if_id_valid); end
        end
        stall = 1'b0;
        step();
        n_checks++; if (if_id_pc !== 32'h8 || if_id_instr !== 32'hA000_0008 || imem_adr !== 32'hC) begin
            n_fail++; $display("FAIL stall_resume got pc=%h ins=%h adr=%h exp 8/a0000008/c", if_id_pc, if_id_instr, imem_adr); end
    endtask

    task automatic test_redirect_over_stall();
        stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h40;
        step();
        stall = 1'b0; redirect = 1'b0;
        n_checks++; if (imem_adr !== 32'h40 || if_id_valid !== 1'b0 || if_id_instr !== NOP) begin
            n_fail++; $display("FAIL redir_stall got adr=%h v=%b ins=%h exp 40/0/%h", imem_adr, if_id_valid, if_id_instr, NOP); end
        step();
        n_checks++; if (if_id_pc !== 32'h40 || if_id_valid !== 1'b1 || if_id_instr !== 32'hA000_0040 || imem_adr !== 32'h44) begin
            n_fail++; $display("FAIL redir_fetch got pc=%h v=%b ins=%h adr=%h exp 40/1/a0000040/44", if_id_pc, if_id_valid, if_id_instr, imem_adr); end
    endtask

    task automatic test_wrap();
        redirect = 1'b1; redirect_pc = 32'h000F_FFFC;
        step();
        redirect = 1'b0;
        n_checks++; if (imem_adr !== 32'h000F_FFFC) begin n_fail++; $display("FAIL wrap_load got %h exp 000ffffc", imem_adr); end
        step();
        n_checks++; if (if_id_pc !== 32'h000F_FFFC || if_id_pc4 !== 32'h0 || imem_adr !== 32'h0) begin
            n_fail++; $display("FAIL wrap got pc=%h pc4=%h adr=%h exp 000ffffc/0/0", if_id_pc, if_id_pc4, imem_adr); end
        redirect = 1'b1; redirect_pc = 32'hFFF0_0010;
        step();
        redirect = 1'b0;
        n_checks++; if (imem_adr !== 32'h10) begin n_fail++; $display("FAIL redir_mask got %h exp 10", imem_adr); end
    endtask

    task automatic test_halt();
        logic [31:0] held;
        step();
        held = imem_adr;
        halt = 1'b1;
        step();
        halt = 1'b0;
        n_checks++; if (state !== 2'd2 || if_id_valid !== 1'b0 || imem_adr !== held) begin
            n_fail++; $display("FAIL halt_enter got st=%0d v=%b adr=%h exp 2/0/%h", state, if_id_valid, imem_adr, held); end
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++; if (state !== 2'd2 || if_id_valid !== 1'b0 || if_id_instr !== NOP || imem_adr !== held) begin
                n_fail++; $display("FAIL halt_stay[%0d] got st=%0d v=%b ins=%h adr=%h exp 2/0/%h/%h", i, state, if_id_valid, if_id_instr, imem_adr, NOP, held); end
        end
        stall = 1'b0;
        redirect = 1'b1; redirect_pc = 32'h100;
        step();
        redirect = 1'b0;
        n_checks++; if (state !== 2'd1 || imem_adr !== 32'h100 || if_id_valid !== 1'b0) begin
            n_fail++; $display("FAIL halt_exit got st=%0d adr=%h v=%b exp 1/100/0", state, imem_adr, if_id_valid); end
        step();
        n_checks++; if (if_id_pc !== 32'h100 || if_id_valid !== 1'b1) begin
            n_fail++; $display("FAIL halt_refetch got pc=%h v=%b exp 100/1", if_id_pc, if_id_valid); end
        halt = 1'b1; redirect = 1'b1; redirect_pc = 32'h200;
        step();
        halt = 1'b0; redirect = 1'b0;
        n_checks++; if (state !== 2'd1 || imem_adr !== 32'h200) begin
            n_fail++; $display("FAIL halt_vs_redir got st=%0d adr=%h exp 1/200", state, imem_adr); end
    endtask

    task automatic test_misalign();
        redirect = 1'b1; redirect_pc = 32'h102;
        step();
        redirect = 1'b0;
`ifdef IF_MISALIGN_TRAP_EN
        n_checks++; if (state !== 2'd2 || misalign !== 1'b1 || imem_adr !== 32'h100 || if_id_valid !== 1'b0) begin
            n_fail++; $display("FAIL misalign_trap got st=%0d m=%b adr=%h v=%b exp 2/1/100/0", state, misalign, imem_adr, if_id_valid); end
        step();
        n_checks++; if (state !== 2'd2 || misalign !== 1'b1 || if_id_valid !== 1'b0) begin
            n_fail++; $display("FAIL misalign_stay got st=%0d m=%b v=%b exp 2/1/0", state, misalign, if_id_valid); end
`else
        n_checks++; if (state !== 2'd1 || misalign !== 1'b0 || imem_adr !== 32'h100 || if_id_valid !== 1'b0) begin
            n_fail++; $display("FAIL misalign_clear got st=%0d m=%b adr=%h v=%b exp 1/0/100/0", state, misalign, imem_adr, if_id_valid); end
        step();
        n_checks++; if (if_id_pc !== 32'h100 || if_id_valid !== 1'b1 || misalign !== 1'b0) begin
            n_fail++; $display("FAIL misalign_run got pc=%h v=%b m=%b exp 100/1/0", if_id_pc, if_id_valid, misalign); end
`endif
    endtask

    task automatic test_async_reset();
        redirect = 1'b1; redirect_pc = 32'h1C;
        step();
        redirect = 1'b0;
        step();
        n_checks++; if (imem_adr !== 32'h20 || state !== 2'd1 || if_id_valid !== 1'b1) begin
            n_fail++; $display("FAIL pre_reset got adr=%h st=%0d v=%b exp 20/1/1", imem_adr, state, if_id_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (imem_adr !== 32'h0 || state !== 2'd0 || if_id_valid !== 1'b0 || if_id_instr !== NOP || if_id_pc !== 32'h0 || if_id_pc4 !== 32'h0 || misalign !== 1'b0) begin
            n_fail++; $display("FAIL async_reset got adr=%h st=%0d v=%b ins=%h pc=%h pc4=%h m=%b exp all reset", imem_adr, state, if_id_valid, if_id_instr, if_id_pc, if_id_pc4, misalign); end
        step();
        rst_n = 1'b1;
        step();
        n_checks++; if (state !== 2'd1 || imem_adr !== 32'h0 || if_id_valid !== 1'b0) begin
            n_fail++; $display("FAIL reboot got st=%0d adr=%h v=%b exp 1/0/0", state, imem_adr, if_id_valid); end
        step();
        n_checks++; if (if_id_instr !== 32'h0050_0093 || if_id_valid !== 1'b1 || imem_adr !== 32'h4) begin
            n_fail++; $display("FAIL reboot_fetch got ins=%h v=%b adr=%h exp 00500093/1/4", if_id_instr, if_id_valid, imem_adr); end
    endtask

    initial begin
        test_reset();
        test_stall();
        test_redirect_over_stall();
        test_wrap();
        test_halt();
        test_misalign();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
